instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 36 +++
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if -- field-set input channel and instruction-memory write
// channel of the instruction encoder, bundled for module ports.
//   Input channel : in_valid, in_ready, in_type, rd, rs1, rs2, imm, clear
//   Write channel : wr_en, wr_addr, wr_data
//   Status        : count, full, err_misalign
// master = the side that supplies fields (bench / upstream loader);
// slave  = the encoder itself.
interface instr_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_type;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [12:0]           imm;
  logic                  clear;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  err_misalign;

  modport master (
    output in_valid, in_type, rd, rs1, rs2, imm, clear,
    input  in_ready, wr_en, wr_addr, wr_data, count, full, err_misalign
  );

  modport slave (
    input  in_valid, in_type, rd, rs1, rs2, imm, clear,
    output in_ready, wr_en, wr_addr, wr_data, count, full, err_misalign
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder -- packs R/I/S/B field sets into RV32 instruction words and
// streams them into an instruction memory at consecutive addresses.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : instr_encoder_if.slave (field input handshake, memory write
//           strobe/address/data, fill count, full flag, misalign pulse)
// One word is accepted per cycle when in_valid && in_ready; the encoded word
// appears on the write port the following cycle. Loading stops once DEPTH
// words are written and resumes only after clear.
module instr_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  // count value that means every address has been written
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_S = 2'b10;
  localparam logic [1:0] TYPE_B = 2'b11;

  logic [0:0]            state_reg,   state_next;
  logic [ADDR_WIDTH:0]   count_reg,   count_next;
  logic                  wr_en_reg,   wr_en_next;
  logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic                  err_reg,     err_next;

  logic        in_ready;
  logic        accept;
  logic        misalign;
  logic        do_write;
  logic [31:0] enc_word;

  // Ready is held low during reset and while clear is asserted so that a
  // field set presented alongside clear is never taken.
  assign in_ready = rst_n && (state_reg == LOAD) && !bus.clear;
  assign accept   = bus.in_valid && in_ready;
  // Branch offsets are in half-words; an odd byte offset cannot be encoded.
  assign misalign = (bus.in_type == TYPE_B) && bus.imm[0];
  assign do_write = accept && !misalign;

  // Unused fields of each format are simply not routed into the word.
  always_comb begin
    enc_word = 32'd0;
    case (bus.in_type)
      TYPE_R: enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
      TYPE_I: enc_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b0010011};
      TYPE_S: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010,
                          bus.imm[4:0], 7'b0100011};
      TYPE_B: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b001,
                          bus.imm[4:1], bus.imm[11], 7'b1100011};
      default: enc_word = 32'd0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    err_next     = 1'b0;

    if (bus.clear) begin
      // Clear outranks everything; nothing is accepted in this cycle, so the
      // following cycle carries no write and no error pulse.
      state_next = LOAD;
      count_next = '0;
    end else begin
      err_next   = accept && misalign;
      wr_en_next = do_write;
      if (do_write) begin
        wr_addr_next = count_reg[ADDR_WIDTH-1:0];
        wr_data_next = DATA_WIDTH'(enc_word);
        count_next   = count_reg + 1'b1;
        if (count_next == DEPTH_CNT) begin
          state_next = FULL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= LOAD;
      count_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      err_reg     <= err_next;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.wr_en        = wr_en_reg;
  assign bus.wr_addr      = wr_addr_reg;
  assign bus.wr_data      = wr_data_reg;
  assign bus.count        = count_reg;
  assign bus.full         = (state_reg == FULL);
  assign bus.err_misalign = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder -- directed bench for instr_encoder (ADDR_WIDTH=2, so the
// memory fills after four words). Expected writes go into a scoreboard queue
// when stimulus is driven; a negedge monitor pops and compares each write.
module tb_instr_encoder;

  localparam int DW = 32;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n;

  instr_encoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_encoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent field-placement model for R and I words.
  function automatic logic [31:0] ref_enc(input logic [1:0] t, input logic [4:0] rd_f,
                                          input logic [4:0] rs1_f, input logic [4:0] rs2_f,
                                          input logic [12:0] imm_f);
    logic [31:0] r;
    r = 32'd0;
    if (t == 2'b00)
      r = (32'(rs2_f) << 20) | (32'(rs1_f) << 15) | (32'(rd_f) << 7) | 32'h33;
    else if (t == 2'b01)
      r = (32'(imm_f & 13'h0FFF) << 20) | (32'(rs1_f) << 15) | (32'(rd_f) << 7) | 32'h13;
    return r;
  endfunction

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] t, input logic [4:0] rd_f, input logic [4:0] rs1_f,
                       input logic [4:0] rs2_f, input logic [12:0] imm_f);
    bus.in_valid = 1'b1;
    bus.in_type  = t;
    bus.rd       = rd_f;
    bus.rs1      = rs1_f;
    bus.rs2      = rs2_f;
    bus.imm      = imm_f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every wr_en cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {62'd0, bus.wr_en}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", bus.wr_addr, e.addr);
        check("wr_data", bus.wr_data, e.data);
        $display("write addr=%0d data=%08h", bus.wr_addr, bus.wr_data);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.in_type  = 2'b00;
    bus.rd       = 5'd0;
    bus.rs1      = 5'd0;
    bus.rs2      = 5'd0;
    bus.imm      = 13'd0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_err", bus.err_misalign, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", bus.in_ready, 1);

    // addi x1,x0,5
    drive(2'b01, 5'd1, 5'd0, 5'd0, 13'd5);
    push(2'd0, 32'h00500093);
    tick();
    bus.in_valid = 1'b0;
    check("addi_wr_en", bus.wr_en, 1);
    check("addi_count", bus.count, 1);
    tick();
    check("addi_wr_en_drop", bus.wr_en, 0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clear_count", bus.count, 0);

    // Four formats back-to-back, with junk in unused fields
    drive(2'b00, 5'd3, 5'd1, 5'd2, 13'h1ABC);
    push(2'd0, 32'h002081B3);
    tick();
    check("b2b_wr_en0", bus.wr_en, 1);
    drive(2'b10, 5'd31, 5'd1, 5'd2, 13'd4);
    push(2'd1, 32'h0020A223);
    tick();
    check("b2b_wr_en1", bus.wr_en, 1);
    drive(2'b11, 5'd17, 5'd1, 5'd2, 13'h1FF8);
    push(2'd2, 32'hFE209CE3);
    tick();
    check("b2b_wr_en2", bus.wr_en, 1);
    drive(2'b01, 5'd5, 5'd3, 5'd9, 13'h1FFF);
    push(2'd3, 32'hFFF18293);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_wr_en3", bus.wr_en, 1);
    check("b2b_full", bus.full, 1);
    check("b2b_ready", bus.in_ready, 0);
    tick();
    check("b2b_wr_en_end", bus.wr_en, 0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;

    // Misaligned branch is dropped; next word keeps the address
    drive(2'b11, 5'd0, 5'd1, 5'd2, 13'd3);
    tick();
    bus.in_valid = 1'b0;
    check("mis_err", bus.err_misalign, 1);
    check("mis_wr_en", bus.wr_en, 0);
    check("mis_count", bus.count, 0);
    tick();
    check("mis_err_pulse", bus.err_misalign, 0);
    drive(2'b01, 5'd2, 5'd1, 5'd0, 13'h07FF);
    push(2'd0, 32'h7FF08113);
    tick();
    bus.in_valid = 1'b0;
    check("mis_next_count", bus.count, 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;

    // Fill: five held words, only four accepted
    for (int i = 0; i < 5; i++) begin
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] c;
      a = 5'(i + 1);
      b = 5'(i);
      c = 5'(i + 2);
      drive(2'b00, a, b, c, 13'd0);
      if (i < 4) push(2'(i), ref_enc(2'b00, a, b, c, 13'd0));
      tick();
      if (i == 3) check("fill_ready_at_4", bus.in_ready, 0);
    end
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 4);
    check("fill_ready", bus.in_ready, 0);
    tick();
    check("fill_hold_count", bus.count, 4);
    bus.clear = 1'b1;
    tick();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("fill_clr_count", bus.count, 0);
    check("fill_clr_full", bus.full, 0);
    check("fill_clr_ready", bus.in_ready, 1);
    drive(2'b01, 5'd7, 5'd6, 5'd0, 13'h0123);
    push(2'd0, ref_enc(2'b01, 5'd7, 5'd6, 5'd0, 13'h0123));
    tick();
    bus.in_valid = 1'b0;
    check("fill_after_clr_addr", bus.wr_addr, 0);
    tick();

    // Clear collides with a new valid one cycle after an accept
    drive(2'b00, 5'd10, 5'd11, 5'd12, 13'd0);
    push(2'd1, ref_enc(2'b00, 5'd10, 5'd11, 5'd12, 13'd0));
    tick();
    drive(2'b00, 5'd20, 5'd21, 5'd22, 13'd0);
    bus.clear = 1'b1;
    #1;
    check("col_ready", bus.in_ready, 0);
    check("col_prior_wr_en", bus.wr_en, 1);
    tick();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    check("col_wr_en", bus.wr_en, 0);
    check("col_count", bus.count, 0);
    tick();

    // Reset mid-stream
    drive(2'b01, 5'd4, 5'd4, 5'd0, 13'd9);
    push(2'd0, ref_enc(2'b01, 5'd4, 5'd4, 5'd0, 13'd9));
    tick();
    drive(2'b01, 5'd8, 5'd8, 5'd0, 13'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0;
    check("mid_rst_wr_en", bus.wr_en, 0);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_addr", bus.wr_addr, 0);
    check("mid_rst_data", bus.wr_data, 0);
    check("mid_rst_err", bus.err_misalign, 0);
    check("mid_rst_full", bus.full, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_wr_en", bus.wr_en, 0);
    tick();

    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
